// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, single-outstanding imem fetch, FWFT instruction queue
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset_,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic            imem_req_q;

    logic [31:0]     data_q [FIFO_DEPTH];
    logic [31:0]     ipc_q  [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q, count_d;

    logic            push, pop, space;
    logic [31:0]     target_pc;
    logic            unused_redirect_lsbs;

    assign target_pc            = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign instr_valid = (count_q != '0);
    assign instr       = data_q[rd_ptr_q];
    assign instr_pc    = ipc_q[rd_ptr_q];
    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;

    // Space is judged on the occupancy after this cycle's push/pop, so a
    // response arriving into a draining queue can chain straight into REQ.
    assign push    = (state_q == S_WAIT) && imem_rvalid && !redirect_valid;
    assign pop     = instr_valid && instr_ready;
    assign count_d = count_q + CW'(push) - CW'(pop);
    assign space   = (count_d < CW'(FIFO_DEPTH));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            S_IDLE: begin
                if (redirect_valid) pc_d = target_pc;
                else if (space)     state_d = S_REQ;
            end
            S_REQ: begin
                if (imem_gnt && redirect_valid) begin
                    state_d = S_DISCARD;
                    pc_d    = target_pc;
                end else if (imem_gnt) begin
                    state_d = S_WAIT;
                end else if (redirect_valid) begin
                    state_d = S_IDLE;
                    pc_d    = target_pc;
                end
            end
            S_WAIT: begin
                if (imem_rvalid && redirect_valid) begin
                    state_d = S_IDLE;
                    pc_d    = target_pc;
                end else if (imem_rvalid) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = space ? S_REQ : S_IDLE;
                end else if (redirect_valid) begin
                    state_d = S_DISCARD;
                    pc_d    = target_pc;
                end
            end
            S_DISCARD: begin
                if (imem_rvalid)    state_d = S_IDLE;
                if (redirect_valid) pc_d = target_pc;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            imem_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            imem_req_q <= (state_d == S_REQ);
        end
    end

    // A redirect flushes the queue outright; any coincident pop is irrelevant.
    always_ff @(posedge clock) begin
        if (!reset_) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i] <= '0;
                ipc_q[i]  <= '0;
            end
        end else if (redirect_valid) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr_q] <= imem_rdata;
                ipc_q[wr_ptr_q]  <= pc_q;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized bench for fetch_unit against an epoch-tagged transaction model
module tb_fetch_unit;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset_ = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    always #5 clock = ~clock;

    fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset_(reset_),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready)
    );

    typedef struct { logic [31:0] d; logic [31:0] pc; } ent_t;

    int checks = 0;
    int errors = 0;

    // stimulus knobs (percentages / max latency)
    int   k_gnt = 100, k_rdy = 0, k_redir = 0, k_dly = 0;
    logic k_rst = 1'b0;
    bit   f_redir = 0, f_dead = 0;
    logic [31:0] f_rpc = '0;

    // reference model: fetch PC, expected queue, one outstanding tagged fetch
    ent_t        q[$];
    logic [31:0] m_pc = RESET_PC;
    bit          m_out = 0;
    int          m_dly = 0, m_tag = 0, epoch = 0, idle_run = 0;
    logic [31:0] m_gaddr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hFFD0_8013;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("pc", imem_addr, m_pc);
        chk("valid", instr_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("instr", instr, q[0].d);
            chk("instr_pc", instr_pc, q[0].pc);
        end
        if (q.size() >= DEPTH || m_out) chk("req_gate", imem_req, 0);
        if (k_rst && !imem_req && !m_out && q.size() < DEPTH) idle_run++;
        else idle_run = 0;
        chk("liveness", idle_run <= 3, 1);
    endtask

    task automatic cycle();
        logic s_req, s_valid, resp, acc, pop, grant;
        logic [31:0] pc_before;
        int ep_before;
        reset_         = k_rst;
        imem_rvalid    = m_out && (m_dly == 0);
        imem_rdata     = imem_rvalid ? (f_dead ? 32'hDEAD_BEEF : mem_word(m_gaddr)) : $urandom;
        imem_gnt       = ($urandom_range(99) < k_gnt);
        redirect_valid = f_redir || ($urandom_range(99) < k_redir);
        redirect_pc    = f_redir ? f_rpc :
                         ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 + $urandom_range(15))
                                                  : $urandom_range(1023);
        instr_ready    = ($urandom_range(99) < k_rdy);
        s_req   = imem_req;
        s_valid = instr_valid;
        @(posedge clock);
        if (!k_rst) begin
            q.delete();
            m_pc = RESET_PC; m_out = 0; epoch = 0; idle_run = 0;
        end else begin
            resp      = imem_rvalid;
            acc       = resp && (m_tag == epoch) && !redirect_valid;
            pop       = s_valid && instr_ready && !redirect_valid;
            grant     = s_req && imem_gnt;
            pc_before = m_pc;
            ep_before = epoch;
            if (redirect_valid) begin
                q.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
                epoch++;
                idle_run = 0;
            end else begin
                if (pop && q.size() > 0) void'(q.pop_front());
                if (acc) begin
                    q.push_back('{imem_rdata, m_pc});
                    m_pc = m_pc + 32'd4;
                end
            end
            if (resp) m_out = 0;
            else if (m_out && m_dly > 0) m_dly--;
            if (grant) begin
                m_out = 1; m_tag = ep_before; m_gaddr = pc_before;
                m_dly = $urandom_range(k_dly);
            end
        end
        f_redir = 0;
        @(negedge clock);
        compare();
    endtask

    task automatic wait_req(input string nm);
        for (int i = 0; i < 30 && !imem_req; i++) cycle();
        chk(nm, imem_req, 1);
    endtask

    task automatic wait_valid(input string nm);
        for (int i = 0; i < 30 && !instr_valid; i++) cycle();
        chk(nm, instr_valid, 1);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_req"}, imem_req, 0);
        chk({nm, "_addr"}, imem_addr, RESET_PC);
        chk({nm, "_valid"}, instr_valid, 0);
        chk({nm, "_instr"}, instr, 0);
        chk({nm, "_ipc"}, instr_pc, 0);
    endtask

    initial begin
        // 1: reset, first fetch at 0 returns FFD08013, next fetch at 4
        k_rst = 1'b0;
        repeat (2) cycle();
        chk_reset_outputs("t1_rst");
        k_rst = 1'b1;
        wait_req("t1_req");
        chk("t1_addr", imem_addr, 32'h0);
        cycle();
        wait_valid("t1_valid");
        chk("t1_instr", instr, 32'hFFD0_8013);
        chk("t1_ipc", instr_pc, 32'h0);
        wait_req("t1_req2");
        chk("t1_addr2", imem_addr, 32'h4);

        // 2: decode stalled, queue fills, fetch stops; one pop resumes at 8
        repeat (8) cycle();
        chk("t2_full_req", imem_req, 0);
        chk("t2_head_pc", instr_pc, 32'h0);
        k_rdy = 100; cycle(); k_rdy = 0;
        chk("t2_pop_pc", instr_pc, 32'h4);
        wait_req("t2_req");
        chk("t2_addr", imem_addr, 32'h8);

        // 3: redirect to 0x40 during WAIT; late DEADBEEF dropped
        k_dly = 3;
        cycle();
        k_dly = 0;
        f_redir = 1; f_rpc = 32'h40; f_dead = 1;
        cycle();
        chk("t3_flush", instr_valid, 0);
        wait_req("t3_req");
        f_dead = 0;
        chk("t3_addr", imem_addr, 32'h40);
        wait_valid("t3_valid");
        chk("t3_ipc", instr_pc, 32'h40);
        chk("t3_instr", instr, mem_word(32'h40));

        // 4: redirect coincident with grant, low bits of target ignored
        k_rdy = 100;
        wait_req("t4_req0");
        f_redir = 1; f_rpc = 32'h42;
        cycle();
        wait_req("t4_req");
        chk("t4_addr", imem_addr, 32'h40);
        wait_valid("t4_valid");
        chk("t4_ipc", instr_pc, 32'h40);

        // 5: PC wraps past the top of the address space
        wait_req("t5_req0");
        f_redir = 1; f_rpc = 32'hFFFF_FFFC;
        cycle();
        wait_req("t5_req");
        chk("t5_addr", imem_addr, 32'hFFFF_FFFC);
        cycle();
        wait_req("t5_req2");
        chk("t5_wrap", imem_addr, 32'h0);

        // 6: reset while a fetch is outstanding with data queued
        k_rdy = 0;
        wait_valid("t6_valid");
        wait_req("t6_req");
        k_dly = 5;
        cycle();
        chk("t6_pre_valid", instr_valid, 1);
        k_rst = 1'b0;
        cycle();
        chk_reset_outputs("t6_rst");
        k_rst = 1'b1;
        k_dly = 0;

        // random traffic
        for (int i = 0; i < 6000; i++) begin
            if (i % 200 == 0) begin
                k_gnt   = $urandom_range(100, 20);
                k_rdy   = $urandom_range(100);
                k_redir = $urandom_range(15);
                k_dly   = $urandom_range(4);
            end
            k_rst = ($urandom_range(499) != 0);
            cycle();
        end
        k_rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
